// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-address loads/stores onto a word-wide data memory.
// Ports: req_* (valid/ready request), rsp_* (one-cycle response), mem_* (memory side).
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_r_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] mem_wdata,
  input  logic [ADDR_WIDTH-1:0] mem_rdata
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] MW = AW'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_ACC, S_RMW_RD, S_RMW_WR, S_ST_WR, S_RESP
  } state_t;

  state_t state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] merge_q, merge_d;
  logic [AW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          accept, f3_ok, misal, oor, bad;
  logic [4:0]    sh;
  logic [AW-1:0] lane, mask, wsh, merged;

  assign req_ready = (state_q == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;

  assign f3_ok = req_we
    ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
    : (req_funct3 inside {3'b000, 3'b001, 3'b010,
                          3'b100, 3'b101});
  assign misal = ((req_funct3[1:0] == 2'b01) & req_addr[0])
               | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
  // No wrap: any word index beyond the memory is an error.
  assign oor   = {2'b00, req_addr[AW-1:2]} >= MW;
  assign bad   = ~f3_ok | misal | oor;

  // Little-endian lane shift; also positions store data/mask.
  assign sh     = {addr_q[1:0], 3'b000};
  assign lane   = mem_rdata >> sh;
  assign mask   = (f3_q[0] ? AW'(32'hFFFF) : AW'(32'hFF)) << sh;
  assign wsh    = wdata_q << sh;
  assign merged = (merge_q & ~mask) | (wsh & mask);

  assign mem_addr  = {2'b00, addr_q[AW-1:2]};
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rsp_valid = 1'b0;
    mem_r_en  = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = bad;
          rdata_d = '0;
          unique case (1'b1)
            bad:                 state_d = S_RESP;
            ~bad & ~req_we:      state_d = S_LD_ACC;
            ~bad & req_we &
              (req_funct3[1:0] == 2'b10):
                                 state_d = S_ST_WR;
            default:             state_d = S_RMW_RD;
          endcase
        end
      end
      S_LD_ACC: begin
        mem_r_en = 1'b1;
        unique case (f3_q)
          3'b000:  rdata_d = {{(AW-8){lane[7]}}, lane[7:0]};
          3'b001:  rdata_d = {{(AW-16){lane[15]}}, lane[15:0]};
          3'b100:  rdata_d = {{(AW-8){1'b0}}, lane[7:0]};
          3'b101:  rdata_d = {{(AW-16){1'b0}}, lane[15:0]};
          default: rdata_d = mem_rdata;
        endcase
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        mem_r_en = 1'b1;
        merge_d  = mem_rdata;
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_wr_en = 1'b1;
        mem_wdata = merged;
        state_d   = S_RESP;
      end
      S_ST_WR: begin
        mem_wr_en = 1'b1;
        mem_wdata = wdata_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit.
// Word memory model, request driver, scoreboard queue checked on rsp_valid.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_r_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_WORDS(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_r_en(mem_r_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] idx;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  logic [31:0] mem [2048];
  logic        bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int acc_n   = 0;
  int seen_n  = 0;
  int in_flight = 0;
  int rd_cnt  = 0;
  int wr_cnt  = 0;

  assign mem_rdata = mem_r_en ? mem[mem_addr[10:0]] : 32'h0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) begin
      acc_n   <= acc_n + 1;
      acc_cyc <= cyc;
    end
    if (mem_wr_en) mem[mem_addr[10:0]] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      in_flight = 0;
      seen_n = acc_n;
    end else begin
      if (acc_n != seen_n) begin
        seen_n = acc_n;
        check("one_inflight", 32'(in_flight), 32'd0);
        in_flight = 1;
        rd_cnt = 0;
        wr_cnt = 0;
        if (q.size() > 0) cur = q[0];
      end
      check("excl_en", {31'd0, mem_r_en & mem_wr_en}, 32'd0);
      if (mem_r_en) rd_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (mem_r_en || mem_wr_en) check("mem_addr", mem_addr, cur.idx);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexp_rsp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("rdata", rsp_rdata, e.rdata);
          check("err", {31'd0, rsp_err}, {31'd0, e.err});
          check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          check("n_reads", 32'(rd_cnt), 32'(e.nrd));
          check("n_writes", 32'(wr_cnt), 32'(e.nwr));
        end
        in_flight = 0;
      end
    end
  end

  task automatic bd_write(input logic [10:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] e_rd, input logic e_err,
                      input int lat, input int nrd, input int nwr,
                      input logic hold);
    exp_t e;
    int n;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata = e_rd; e.err = e_err; e.lat = lat;
    e.nrd = nrd; e.nwr = nwr; e.idx = a >> 2;
    q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_r_en", {31'd0, mem_r_en}, 32'd0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    bd_write(11'd3, 32'h00AB_CD00);
    bd_write(11'd5, 32'h5566_7788);
    bd_write(11'd2047, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b0;

    // Loads with lane select and extension
    send(0, 3'b000, 32'h0D, 32'h0, 32'hFFFF_FFCD, 0, 2, 1, 0, 0);
    send(0, 3'b100, 32'h0D, 32'h0, 32'h0000_00CD, 0, 2, 1, 0, 0);
    send(0, 3'b101, 32'h0E, 32'h0, 32'h0000_00AB, 0, 2, 1, 0, 0);
    send(0, 3'b010, 32'h0C, 32'h0, 32'h00AB_CD00, 0, 2, 1, 0, 0);
    send(0, 3'b001, 32'h0C, 32'h0, 32'hFFFF_CD00, 0, 2, 1, 0, 0);
    send(0, 3'b000, 32'h0E, 32'h0, 32'hFFFF_FFAB, 0, 2, 1, 0, 0);
    send(0, 3'b000, 32'h0F, 32'h0, 32'h0000_0000, 0, 2, 1, 0, 0);
    send(0, 3'b010, 32'h1FFC, 32'h0, 32'hDEAD_BEEF, 0, 2, 1, 0, 0);

    // Sub-word stores through read-modify-write
    send(1, 3'b000, 32'h0C, 32'hFFFF_FF11, 32'h0, 0, 3, 1, 1, 0);
    drain();
    check("sb_word", mem[3], 32'h00AB_CD11);
    send(1, 3'b001, 32'h0E, 32'h0000_1234, 32'h0, 0, 3, 1, 1, 0);
    drain();
    check("sh_word", mem[3], 32'h1234_CD11);
    send(0, 3'b101, 32'h0E, 32'h0, 32'h0000_1234, 0, 2, 1, 0, 0);
    send(0, 3'b001, 32'h0E, 32'h0, 32'h0000_1234, 0, 2, 1, 0, 0);

    // Error classification: no memory access, one-cycle response
    send(0, 3'b001, 32'h0D, 32'h0, 32'h0, 1, 1, 0, 0, 0);
    send(1, 3'b010, 32'h0E, 32'h5, 32'h0, 1, 1, 0, 0, 0);
    send(0, 3'b011, 32'h0C, 32'h0, 32'h0, 1, 1, 0, 0, 0);
    send(0, 3'b010, 32'h2000, 32'h0, 32'h0, 1, 1, 0, 0, 0);
    send(1, 3'b100, 32'h0C, 32'h7, 32'h0, 1, 1, 0, 0, 0);
    send(0, 3'b110, 32'h0C, 32'h0, 32'h0, 1, 1, 0, 0, 0);
    send(1, 3'b000, 32'hFFFF_FFFF, 32'h7, 32'h0, 1, 1, 0, 0, 0);
    drain();
    check("err_no_write", mem[3], 32'h1234_CD11);

    // Back-to-back with req_valid held high
    send(1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 2, 0, 1, 1);
    send(0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 2, 1, 0, 0);
    drain();

    // Reset in the middle of a read-modify-write
    send(1, 3'b000, 32'h14, 32'h0000_0099, 32'h0, 0, 3, 1, 1, 0);
    check("rmw_rd_en", {31'd0, mem_r_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_r_en", {31'd0, mem_r_en}, 32'd0);
    check("rst_mid_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    check("rst_lost_store", mem[5], 32'h5566_7788);
    check("rst_rdata_clr", rsp_rdata, 32'd0);

    send(0, 3'b010, 32'h14, 32'h0, 32'h5566_7788, 0, 2, 1, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
